// File: rtl/booth_seq_mul.sv
// booth_seq_mul: radix-2 Booth sequential signed multiplier with start/done handshake
module booth_seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, next_state;
  logic [N:0]    m, acc, neg_m, addend, s;
  logic [N-1:0]  q;
  logic          q_1;
  logic [CW-1:0] cnt;
  logic          last;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb begin
    next_state = state;
    if (state == IDLE && start) next_state = ITER;
    else if (state == ITER && last) next_state = DONE;
    else if (state == DONE) next_state = IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // Shared negation unit; N+1 bits so negating -2^(N-1) cannot overflow
  assign neg_m  = ~m + 1'b1;
  assign addend = ({q[0], q_1} == 2'b01) ? m : ({q[0], q_1} == 2'b10) ? neg_m : '0;
  assign s      = acc + addend;
  assign last   = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      P   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        m   <= {A[N-1], A};
        acc <= '0;
        q   <= B;
        q_1 <= 1'b0;
        cnt <= CW'(N);
      end
    end else if (state == ITER) begin
      acc <= {s[N], s[N:1]};
      q   <= {s[0], q[N-1:1]};
      q_1 <= q[0];
      cnt <= cnt - CW'(1);
      // Post-shift {acc[N-1:0], q}; the redundant sign bit acc[N] is dropped
      if (last) P <= {s[N:0], q[N-1:1]};
    end
  end
endmodule

// File: doc/booth_seq_mul.md
# booth_seq_mul

Sequential signed multiplier for the ALU. It implements the radix-2 Booth algorithm by time-sharing one (N+1)-bit adder and one (N+1)-bit two's-complement unit over N iteration cycles. It sits beside the combinational ALU ops and serves multi-cycle MUL instructions under a start/done handshake. The core stalls on `busy` and captures `P` on `done`.

## Interface

Parameters:
- `N`, default 8, operand width; product width is 2N.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; only sampled while idle.
- `A`  input  N  multiplicand, signed two's complement.
- `B`  input  N  multiplier, signed two's complement.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `done`  output  1  single-cycle pulse; `P` is valid for the new operation.
- `P`  output  2N  signed product; holds its value until the next completion.

## Operation

- **Registers:**
  - `M`: N+1 bits, sign-extended `A`.
  - `ACC`: N+1 bits.
  - `Q`: N bits.
  - `Q_1`: 1 bit.
  - `CNT`: counts N down to 0.
  - `P`: 2N bits.
- **FSM states:** IDLE, ITER, DONE.
- **IDLE:**
  - If `start` is 1: load `M={A[N-1],A}`, `ACC=0`, `Q=B`, `Q_1=0`, `CNT=N`, then go to ITER.
  - Otherwise stay in IDLE.
- **ITER:** one Booth step per cycle.
  - `{Q[0],Q_1}`=01 gives `S=ACC+M`.
  - `{Q[0],Q_1}`=10 gives `S=ACC+(~M+1)`, where `~M+1` comes from the shared two's-complement unit at width N+1.
  - `{Q[0],Q_1}`=00 or 11 gives `S=ACC`.
  - Then arithmetic right shift: `{ACC,Q,Q_1} <= {S[N],S,Q}` truncated to 2N+2 bits. In other words, `ACC<={S[N],S[N:1]}`, `Q<={S[0],Q[N-1:1]}`, `Q_1<=Q[0]`.
  - `CNT` decrements by 1 each ITER cycle.
  - On the step where `CNT==1`: load `P` with the post-shift `{ACC[N-1:0],Q}` and go to DONE.
- **DONE:** `done=1` and `busy=1`; go to IDLE unconditionally.
- **Width rule:**
  - The accumulator is N+1 bits, so negating `M=-2^(N-1)` does not overflow.
  - Product bits are the low 2N bits of `{ACC,Q}`; `ACC[N]` is a redundant sign bit and is discarded.
  - All 2^(2N) operand pairs give the exact signed product, including `(-2^(N-1))*(-2^(N-1)) = 2^(2N-2)`.
- **Boundary conditions:**
  - `start` while ITER or DONE is ignored; no queueing.
  - Changes to `A`/`B` after the accept edge have no effect.
  - `start` held continuously re-launches on each IDLE cycle, giving one operation per N+2 cycles.
  - `rst` in any state: next state IDLE, `busy=0`, `done=0`, `P=0`. The in-flight result is discarded and no `done` is emitted.
  - `B=0` or `A=0` still takes the full N iterations; latency is data-independent.

## Timing

- **Reset values:** `busy=0`, `done=0`, `P=0`, state IDLE, internal registers 0.
- **Accept edge:** call it k, with `start=1` and the FSM in IDLE.
- **Iterations:** at edges k+1 … k+N.
- **Completion:**
  - At edge k+N, `P` is updated and the FSM enters DONE.
  - `done=1` for exactly the cycle between edges k+N and k+N+1.
- **busy:** 1 from after edge k through the DONE cycle, i.e. N+1 cycles.
- **Earliest next accept:** edge k+N+2, giving a throughput of N+2 cycles per product.
- **Outputs:** `done`, `busy` and `P` are registered or derived from state only, with no combinational path from inputs.

## Test plan

- **Positive operands:** N=8, A=7, B=3, one start pulse → `done` exactly 8 cycles after the accept edge, `P=16'h0015`; `busy` high 9 cycles.
- **Mixed sign:** A=-5 (8'hFB), B=6 → `P=16'hFFE2` (-30). Also A=6, B=-5 gives the same `P`.
- **Extremes:** A=B=8'h80 → `P=16'h4000`. A=8'h80, B=8'h7F → `P=16'hC080`. A=8'h7F, B=8'h7F → `P=16'h3F01`.
- **Busy rejection:** start accepted with A=3, B=4. Pulse `start` with A=9, B=9 during ITER → result `P=16'h000C`, only one `done` pulse. Holding `start` high then relaunches at the first IDLE cycle, with the next `done` N+2 cycles after the previous one.
- **Reset mid-operation:** start with A=-1, B=-1. Assert `rst` at cycle 4 of ITER → next cycle `busy=0`, `done=0`, `P=0`, and no `done` appears afterwards. A new start with A=2, B=-3 then yields `P=16'hFFFA`.
- **Exhaustive sweep:** N=4, all 256 operand pairs back-to-back → each `P` equals the signed reference product, and `done` spacing is always 6 cycles.
